layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Run-level controller for the L1–L17 SqueezeNext pipeline.
- Accepts a start pulse and issues a one-cycle `layer_start` to each of the NUM_LAYERS layer engines in order, waiting for each `layer_done` before issuing the next.
- Toggles the ping-pong feature-buffer select between layers and flags hung layers with a watchdog.
- Counts total run cycles and pulses `capture_en` so the 128-bit final-layer outputs are latched exactly once per run.

## Interface
- NUM_LAYERS, 17, number of layers sequenced (layer_idx runs 1..NUM_LAYERS)
- IDX_W, 5, width of layer_idx
- TIMEOUT, 4096, max cycles a layer may spend in WAIT before ERROR (≥2)
- CNT_W, 24, width of run_cycles

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  run request; honoured only in IDLE
- pause  in  1  holds sequencer between layers (NEXT state only)
- clear  in  1  leaves ERROR; ignored in other states
- layer_done  in  1  current layer finished; sampled only in WAIT
- layer_start  out  1  one-cycle pulse to the layer selected by layer_idx
- layer_idx  out  IDX_W  active layer, 1..NUM_LAYERS; 0 when idle
- buf_sel  out  1  ping-pong buffer select; layer reads buf_sel, writes ~buf_sel
- busy  out  1  high from start acceptance until FINISH completes
- capture_en  out  1  one-cycle pulse when the last layer completes; latches out1/out2_layer17
- done  out  1  one-cycle run-complete pulse, coincident with capture_en
- err  out  1  sticky watchdog error
- run_cycles  out  CNT_W  cycles of the last or current run; saturates at all-ones

## Operation
- All outputs are registered, Moore-style, and decoded from state and counters.
- Reset values: state IDLE, layer_idx 0, buf_sel 0, every pulse output 0, busy 0, err 0, run_cycles 0, watchdog 0.
- Reset asserted mid-run aborts immediately to the reset values. No layer_start is issued after reset deasserts until a new start arrives.

States:
- IDLE
  - start=1 → ISSUE.
  - Set layer_idx=1, buf_sel=0, run_cycles=0, busy=1.
- ISSUE
  - layer_start=1 for exactly this cycle.
  - Clear the watchdog.
  - → WAIT.
- WAIT
  - Watchdog increments each cycle.
  - layer_done=1 and layer_idx<NUM_LAYERS → NEXT.
  - layer_done=1 and layer_idx==NUM_LAYERS → FINISH.
  - layer_done=0 and watchdog==TIMEOUT-1 → ERROR.
  - layer_done and timeout in the same cycle: done wins.
- NEXT
  - On entry: layer_idx+1 and buf_sel toggles (applied once, on the WAIT→NEXT edge).
  - pause=1 → stay in NEXT.
  - pause=0 → ISSUE.
- FINISH
  - capture_en=1 and done=1 for this one cycle.
  - → IDLE.
  - On the IDLE entry: busy=0, layer_idx=0. buf_sel and run_cycles hold.
- ERROR
  - err=1, busy=0. layer_idx holds the hung layer. start is ignored.
  - clear=1 → IDLE, with err=0 and layer_idx=0.

Other rules:
- layer_done outside WAIT is ignored, including during ISSUE (0-cycle layers are illegal).
- start outside IDLE is ignored; there is no queuing.
- run_cycles increments every cycle busy=1, saturating at 2^CNT_W-1, and freezes when busy falls.
- pause has no effect outside NEXT.

## Timing
- start sampled at edge N → layer_start high during cycle N..N+1 with layer_idx=1.
- layer_done sampled at edge M (not last layer) → NEXT during M..M+1 → layer_start for the next layer during M+1..M+2 when pause=0. Gap is 2 cycles from done to next start.
- Last layer done at edge M → capture_en/done high during M..M+1 → busy low from M+1.
- Minimum run with 1-cycle layers: each layer takes ISSUE 1 + WAIT 1 + NEXT 1 cycles, and the last replaces NEXT with FINISH, giving 3·NUM_LAYERS cycles = 51 at the default.
- Watchdog: ERROR is entered at the TIMEOUT-th WAIT edge without done.
- buf_sel is stable throughout each layer's ISSUE and WAIT.

## Test plan
- Reset mid-WAIT on layer 5 → next cycle all outputs at reset values. No layer_start for 20 cycles with start=0.
- Nominal run, bench answers layer_done 3 cycles after each layer_start → layer_start count 17 with idx 1..17 in order; buf_sel toggles 16 times; a single capture_en/done pulse; run_cycles=85; busy falls the cycle after done.
- pause=1 held 5 cycles while in NEXT after layer 8 → layer 9 start delayed by exactly 5 cycles; run_cycles grows by 5.
- TIMEOUT=8, layer 3 never done → ERROR 8 cycles after its WAIT entry, with err=1, layer_idx=3, busy=0; start ignored; clear → IDLE, err=0; a following run completes normally.
- layer_done high during ISSUE and in IDLE → ignored; the sequencer stays in WAIT. start pulsed during busy → no second run and no extra layer_start.
- CNT_W=4 with a slow run (>15 cycles) → run_cycles saturates at 15.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Run-control and layer-engine bundle for layer_sequencer.
// master: sequencer side. Drives layer_start, layer_idx, buf_sel, busy,
//         capture_en, done, err and run_cycles.
// slave:  environment side. Drives start, pause, clear and layer_done.
interface layer_sequencer_if #(
  parameter int unsigned IDX_W = 5,
  parameter int unsigned CNT_W = 24
);
  logic             start;
  logic             pause;
  logic             clear;
  logic             layer_done;
  logic             layer_start;
  logic [IDX_W-1:0] layer_idx;
  logic             buf_sel;
  logic             busy;
  logic             capture_en;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] run_cycles;

  modport master (
    input  start, pause, clear, layer_done,
    output layer_start, layer_idx, buf_sel, busy, capture_en, done, err, run_cycles
  );

  modport slave (
    output start, pause, clear, layer_done,
    input  layer_start, layer_idx, buf_sel, busy, capture_en, done, err, run_cycles
  );
endinterface

// File: rtl/layer_sequencer.sv
// Run-level controller for the SqueezeNext layer pipeline.
// Issues a one-cycle layer_start to layers 1..NUM_LAYERS in order, waiting for
// each layer_done, toggles the ping-pong buffer select between layers, trips a
// sticky error when a layer hangs, counts run cycles and pulses capture_en/done
// once when the last layer completes.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - layer_sequencer_if.master (start/pause/clear/layer_done in;
//          layer_start/layer_idx/buf_sel/busy/capture_en/done/err/run_cycles out)
module layer_sequencer #(
  parameter int unsigned NUM_LAYERS = 17,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned CNT_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  layer_sequencer_if.master bus
);
  localparam int unsigned      WD_W     = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             layer_start_q;
  logic             busy_q;
  logic             capture_q;
  logic             done_q;
  logic             err_q;
  logic             buf_sel_q;
  logic [IDX_W-1:0] layer_idx_q;
  logic [CNT_W-1:0] run_cycles_q;
  logic [WD_W-1:0]  wd_q;
  logic             last_layer;
  logic             wd_expired;

  assign last_layer = (layer_idx_q == LAST_IDX);
  assign wd_expired = (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        // A done arriving on the timeout cycle still counts as a completion.
        if (bus.layer_done) state_nxt = last_layer ? S_FINISH : S_NEXT;
        else if (wd_expired) state_nxt = S_ERROR;
      end
      S_NEXT:   if (!bus.pause) state_nxt = S_ISSUE;
      S_FINISH: state_nxt = S_IDLE;
      S_ERROR:  if (bus.clear) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Flag outputs are registered from the next state so each lines up with the
  // cycle its state occupies; index/buffer/counters update on transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      capture_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      buf_sel_q     <= 1'b0;
      layer_idx_q   <= '0;
      run_cycles_q  <= '0;
      wd_q          <= '0;
    end else begin
      layer_start_q <= (state_nxt == S_ISSUE);
      busy_q        <= (state_nxt inside {S_ISSUE, S_WAIT, S_NEXT, S_FINISH});
      capture_q     <= (state_nxt == S_FINISH);
      done_q        <= (state_nxt == S_FINISH);
      err_q         <= (state_nxt == S_ERROR);

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            layer_idx_q <= IDX_W'(1);
            buf_sel_q   <= 1'b0;
          end
        end
        S_ISSUE: wd_q <= '0;
        S_WAIT: begin
          if (bus.layer_done) begin
            if (!last_layer) begin
              layer_idx_q <= layer_idx_q + IDX_W'(1);
              buf_sel_q   <= ~buf_sel_q;
            end
          end else if (!wd_expired) begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_FINISH: layer_idx_q <= '0;
        S_ERROR:  if (bus.clear) layer_idx_q <= '0;
        default: ;
      endcase

      if (state == S_IDLE && bus.start) run_cycles_q <= '0;
      else if (busy_q && run_cycles_q != '1) run_cycles_q <= run_cycles_q + CNT_W'(1);
    end
  end

  assign bus.layer_start = layer_start_q;
  assign bus.layer_idx   = layer_idx_q;
  assign bus.buf_sel     = buf_sel_q;
  assign bus.busy        = busy_q;
  assign bus.capture_en  = capture_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.run_cycles  = run_cycles_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer. Two instances: default parameters, and
// a small one (TIMEOUT=8, CNT_W=4) for the watchdog and counter saturation.
// The inputs of the deselected instance are held low.
module tb_layer_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic start_i, pause_i, clear_i, done_i;

  always #5 clk = ~clk;

  layer_sequencer_if #(.IDX_W(5), .CNT_W(24)) b_bus ();
  layer_sequencer_if #(.IDX_W(5), .CNT_W(4))  s_bus ();

  layer_sequencer #(.NUM_LAYERS(17), .IDX_W(5), .TIMEOUT(4096), .CNT_W(24)) u_big (
    .clk(clk), .rst(rst), .bus(b_bus)
  );
  layer_sequencer #(.NUM_LAYERS(17), .IDX_W(5), .TIMEOUT(8), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .bus(s_bus)
  );

  assign b_bus.start      = start_i & ~sel;
  assign b_bus.pause      = pause_i & ~sel;
  assign b_bus.clear      = clear_i & ~sel;
  assign b_bus.layer_done = done_i  & ~sel;
  assign s_bus.start      = start_i & sel;
  assign s_bus.pause      = pause_i & sel;
  assign s_bus.clear      = clear_i & sel;
  assign s_bus.layer_done = done_i  & sel;

  logic obs_ls, obs_buf, obs_busy, obs_cap, obs_done, obs_err;
  int   obs_idx, obs_rc;
  assign obs_ls   = sel ? s_bus.layer_start : b_bus.layer_start;
  assign obs_buf  = sel ? s_bus.buf_sel     : b_bus.buf_sel;
  assign obs_busy = sel ? s_bus.busy        : b_bus.busy;
  assign obs_cap  = sel ? s_bus.capture_en  : b_bus.capture_en;
  assign obs_done = sel ? s_bus.done        : b_bus.done;
  assign obs_err  = sel ? s_bus.err         : b_bus.err;
  assign obs_idx  = sel ? int'(s_bus.layer_idx)  : int'(b_bus.layer_idx);
  assign obs_rc   = sel ? int'(s_bus.run_cycles) : int'(b_bus.run_cycles);

  int checks = 0;
  int errors = 0;
  int tcount = 0;

  // Statistics gathered by run_seq.
  int st_starts, st_first_idx, st_last_idx, st_order_ok, st_bufsel_ok, st_toggles;
  int st_caps, st_dones, st_coinc_bad, st_busy_at_done, st_busy_after, st_idx_after;
  int st_err_tick, st_finished;
  int start_tick [0:31];

  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
  endtask

  // Runs the selected instance, answering each layer_start with a one-cycle
  // layer_done after dly WAIT cycles. Optional: hold pause for pause_len
  // cycles in the NEXT state that follows layer pause_idx; return in WAIT of
  // layer stop_idx; never answer layer hang_idx (returns once err is seen).
  task automatic run_seq(input int dly, input int pause_idx, input int pause_len,
                         input int stop_idx, input int hang_idx, input bit do_start);
    int countdown = 0;
    int pcnt      = 0;
    bit drove     = 0;
    bit was_done  = 0;
    bit saw_done  = 0;
    bit stop_flag = 0;
    logic prev_buf;
    st_starts = 0; st_first_idx = -1; st_last_idx = -1; st_order_ok = 1; st_bufsel_ok = 1;
    st_toggles = 0; st_caps = 0; st_dones = 0; st_coinc_bad = 0; st_busy_at_done = -1;
    st_busy_after = -1; st_idx_after = -1; st_err_tick = -1; st_finished = 0;
    for (int i = 0; i < 32; i++) start_tick[i] = -1;
    if (do_start) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
    prev_buf = obs_buf;
    for (int c = 0; c < 3000; c++) begin
      if (saw_done) begin
        st_busy_after = int'(obs_busy);
        st_idx_after  = obs_idx;
        st_finished   = 1;
        break;
      end
      if (stop_flag) begin
        st_finished = 1;
        break;
      end
      was_done = drove;
      drove    = 0;
      done_i   = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          done_i = 1'b1;
          drove  = 1;
        end
      end
      if (obs_buf !== prev_buf) st_toggles++;
      prev_buf = obs_buf;
      if (obs_ls) begin
        st_starts++;
        if (st_starts == 1) st_first_idx = obs_idx;
        else if (obs_idx != st_last_idx + 1) st_order_ok = 0;
        st_last_idx = obs_idx;
        if (int'(obs_buf) != ((obs_idx - 1) % 2)) st_bufsel_ok = 0;
        if (obs_idx >= 0 && obs_idx < 32) start_tick[obs_idx] = tcount;
        if (obs_idx == stop_idx) stop_flag = 1;
        countdown = (obs_idx == hang_idx) ? 0 : dly;
      end
      if (obs_cap) st_caps++;
      if (obs_done) st_dones++;
      if (obs_cap !== obs_done) st_coinc_bad++;
      if (obs_err) begin
        st_err_tick = tcount;
        st_finished = 1;
        break;
      end
      if (obs_done) begin
        st_busy_at_done = int'(obs_busy);
        saw_done = 1;
      end
      if (was_done && pause_len > 0 && obs_idx == pause_idx + 1) begin
        pause_i = 1'b1;
        pcnt    = pause_len;
      end else if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) pause_i = 1'b0;
      end
      tick();
    end
    done_i  = 1'b0;
    pause_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (obs_ls !== 1'b0)   begin errors++; $display("FAIL reset_layer_start got %0d want 0", obs_ls); end
    checks++; if (obs_idx != 0)      begin errors++; $display("FAIL reset_layer_idx got %0d want 0", obs_idx); end
    checks++; if (obs_buf !== 1'b0)  begin errors++; $display("FAIL reset_buf_sel got %0d want 0", obs_buf); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", obs_busy); end
    checks++; if ({obs_cap, obs_done, obs_err} !== 3'b000)
                begin errors++; $display("FAIL reset_pulses got %b want 000", {obs_cap, obs_done, obs_err}); end
    checks++; if (obs_rc != 0)       begin errors++; $display("FAIL reset_run_cycles got %0d want 0", obs_rc); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    run_seq(3, 0, 0, 0, 0, 1);
    checks++; if (st_finished != 1)   begin errors++; $display("FAIL nom_completes got %0d want 1", st_finished); end
    checks++; if (st_starts != 17)    begin errors++; $display("FAIL nom_starts got %0d want 17", st_starts); end
    checks++; if (st_first_idx != 1 || st_last_idx != 17 || st_order_ok != 1)
                begin errors++; $display("FAIL nom_idx_order got first %0d last %0d ok %0d want 1 17 1", st_first_idx, st_last_idx, st_order_ok); end
    checks++; if (st_bufsel_ok != 1)  begin errors++; $display("FAIL nom_buf_sel_per_layer got %0d want 1", st_bufsel_ok); end
    checks++; if (st_toggles != 16)   begin errors++; $display("FAIL nom_buf_toggles got %0d want 16", st_toggles); end
    checks++; if (st_caps != 1 || st_dones != 1)
                begin errors++; $display("FAIL nom_capture_done got %0d %0d want 1 1", st_caps, st_dones); end
    checks++; if (st_coinc_bad != 0)  begin errors++; $display("FAIL nom_capture_eq_done got %0d want 0", st_coinc_bad); end
    checks++; if (st_busy_at_done != 1 || st_busy_after != 0)
                begin errors++; $display("FAIL nom_busy_fall got %0d %0d want 1 0", st_busy_at_done, st_busy_after); end
    checks++; if (st_idx_after != 0)  begin errors++; $display("FAIL nom_idx_idle got %0d want 0", st_idx_after); end
    checks++; if (start_tick[2] - start_tick[1] != 5)
                begin errors++; $display("FAIL nom_start_spacing got %0d want 5", start_tick[2] - start_tick[1]); end
    checks++; if (obs_rc != 85)       begin errors++; $display("FAIL nom_run_cycles got %0d want 85", obs_rc); end
    repeat (3) tick();
    checks++; if (obs_rc != 85)       begin errors++; $display("FAIL nom_run_cycles_frozen got %0d want 85", obs_rc); end
  endtask

  task automatic test_min_run();
    run_seq(1, 0, 0, 0, 0, 1);
    checks++; if (st_starts != 17)    begin errors++; $display("FAIL min_starts got %0d want 17", st_starts); end
    checks++; if (obs_rc != 51)       begin errors++; $display("FAIL min_run_cycles got %0d want 51", obs_rc); end
    tick();
  endtask

  task automatic test_pause();
    run_seq(3, 8, 5, 0, 0, 1);
    checks++; if (st_starts != 17)    begin errors++; $display("FAIL pause_starts got %0d want 17", st_starts); end
    checks++; if (start_tick[8] - start_tick[7] != 5)
                begin errors++; $display("FAIL pause_gap_7_8 got %0d want 5", start_tick[8] - start_tick[7]); end
    checks++; if (start_tick[9] - start_tick[8] != 10)
                begin errors++; $display("FAIL pause_gap_8_9 got %0d want 10", start_tick[9] - start_tick[8]); end
    checks++; if (start_tick[10] - start_tick[9] != 5)
                begin errors++; $display("FAIL pause_gap_9_10 got %0d want 5", start_tick[10] - start_tick[9]); end
    checks++; if (obs_rc != 90)       begin errors++; $display("FAIL pause_run_cycles got %0d want 90", obs_rc); end
    tick();
  endtask

  task automatic test_spurious();
    int n;
    done_i = 1'b1;
    repeat (3) tick();
    checks++; if ({obs_ls, obs_busy} !== 2'b00 || obs_idx != 0)
                begin errors++; $display("FAIL idle_done_ignored got ls/busy %b idx %0d want 00 0", {obs_ls, obs_busy}, obs_idx); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (obs_ls !== 1'b1 || obs_idx != 1)
                begin errors++; $display("FAIL spur_first_start got ls %0d idx %0d want 1 1", obs_ls, obs_idx); end
    tick();
    done_i = 1'b0;
    checks++; if (obs_idx != 1 || obs_busy !== 1'b1 || obs_ls !== 1'b0)
                begin errors++; $display("FAIL issue_done_ignored got idx %0d busy %0d ls %0d want 1 1 0", obs_idx, obs_busy, obs_ls); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    repeat (4) begin
      tick();
      if (obs_ls) n++;
    end
    checks++; if (n != 0 || obs_idx != 1 || obs_busy !== 1'b1)
                begin errors++; $display("FAIL wait_holds got starts %0d idx %0d busy %0d want 0 1 1", n, obs_idx, obs_busy); end
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checks++; if (obs_idx != 2 || obs_buf !== 1'b1)
                begin errors++; $display("FAIL spur_next got idx %0d buf %0d want 2 1", obs_idx, obs_buf); end
    run_seq(3, 0, 0, 0, 0, 0);
    checks++; if (st_starts != 16 || st_first_idx != 2 || st_last_idx != 17 || st_dones != 1)
                begin errors++; $display("FAIL spur_rest got starts %0d first %0d last %0d dones %0d want 16 2 17 1", st_starts, st_first_idx, st_last_idx, st_dones); end
    n = 0;
    repeat (6) begin
      tick();
      if (obs_ls || obs_busy) n++;
    end
    checks++; if (n != 0)             begin errors++; $display("FAIL no_second_run got %0d want 0", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    run_seq(3, 0, 0, 5, 0, 1);
    checks++; if (obs_idx != 5 || obs_busy !== 1'b1)
                begin errors++; $display("FAIL mid_reach_wait5 got idx %0d busy %0d want 5 1", obs_idx, obs_busy); end
    rst = 1'b0;
    #1;
    checks++; if ({obs_ls, obs_buf, obs_busy, obs_cap, obs_done, obs_err} !== 6'b0 || obs_idx != 0 || obs_rc != 0)
                begin errors++; $display("FAIL mid_reset_async got flags %b idx %0d rc %0d want 0 0 0", {obs_ls, obs_buf, obs_busy, obs_cap, obs_done, obs_err}, obs_idx, obs_rc); end
    tick();
    checks++; if ({obs_ls, obs_buf, obs_busy, obs_cap, obs_done, obs_err} !== 6'b0 || obs_idx != 0 || obs_rc != 0)
                begin errors++; $display("FAIL mid_reset_next got flags %b idx %0d rc %0d want 0 0 0", {obs_ls, obs_buf, obs_busy, obs_cap, obs_done, obs_err}, obs_idx, obs_rc); end
    rst = 1'b1;
    n = 0;
    repeat (20) begin
      tick();
      if (obs_ls || obs_busy) n++;
    end
    checks++; if (n != 0)             begin errors++; $display("FAIL mid_no_restart got %0d want 0", n); end
  endtask

  task automatic test_timeout();
    int n;
    sel = 1'b1;
    tick();
    run_seq(3, 0, 0, 0, 3, 1);
    checks++; if (st_err_tick < 0 || st_err_tick - start_tick[3] != 9)
                begin errors++; $display("FAIL wd_latency got %0d want 9", st_err_tick - start_tick[3]); end
    checks++; if (obs_err !== 1'b1 || obs_idx != 3 || obs_busy !== 1'b0)
                begin errors++; $display("FAIL wd_state got err %0d idx %0d busy %0d want 1 3 0", obs_err, obs_idx, obs_busy); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = int'(obs_ls);
    tick();
    n += int'(obs_ls);
    checks++; if (n != 0 || obs_err !== 1'b1 || obs_busy !== 1'b0)
                begin errors++; $display("FAIL err_ignores_start got starts %0d err %0d busy %0d want 0 1 0", n, obs_err, obs_busy); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++; if (obs_err !== 1'b0 || obs_idx != 0 || obs_busy !== 1'b0)
                begin errors++; $display("FAIL clear_to_idle got err %0d idx %0d busy %0d want 0 0 0", obs_err, obs_idx, obs_busy); end
    run_seq(3, 0, 0, 0, 0, 1);
    checks++; if (st_starts != 17 || st_caps != 1 || st_busy_after != 0 || obs_err !== 1'b0)
                begin errors++; $display("FAIL recover_run got starts %0d caps %0d busy %0d err %0d want 17 1 0 0", st_starts, st_caps, st_busy_after, obs_err); end
    checks++; if (obs_rc != 15)       begin errors++; $display("FAIL recover_run_cycles got %0d want 15", obs_rc); end
  endtask

  task automatic test_saturate();
    tick();
    run_seq(1, 0, 0, 0, 0, 1);
    checks++; if (st_starts != 17 || st_dones != 1)
                begin errors++; $display("FAIL sat_run got starts %0d dones %0d want 17 1", st_starts, st_dones); end
    checks++; if (obs_rc != 15)       begin errors++; $display("FAIL sat_run_cycles got %0d want 15", obs_rc); end
    sel = 1'b0;
    tick();
  endtask

  initial begin
    rst     = 1'b0;
    sel     = 1'b0;
    start_i = 1'b0;
    pause_i = 1'b0;
    clear_i = 1'b0;
    done_i  = 1'b0;
    test_reset();
    test_nominal();
    test_min_run();
    test_pause();
    test_spurious();
    test_reset_mid();
    test_timeout();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
